key_schedule_engine: RTL and testbench
======================================

KEY_SCHEDULE_ENGINE -- requirements
Module: key_schedule_engine

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning the key-schedule word width; only 32 is legal.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning the round-key read address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port resetn, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to expand key_in.
REQ-006 SHALL have port key_len, input, 2, the key-length code: 00 = AES-128 (Nk=4), 01 = AES-192 (Nk=6), 10 = AES-256 (Nk=8), 11 = illegal.
REQ-007 SHALL have port key_in, input, 256, the cipher key; w[0] is key_in[255:224], and shorter keys use the upper Nk*32 bits.
REQ-008 SHALL have port ready, output, 1, high when start will be accepted.
REQ-009 SHALL have port busy, output, 1, high while expansion is in progress.
REQ-010 SHALL have port valid, output, 1, high when the complete schedule is stored.
REQ-011 SHALL have port err, output, 1, a one-cycle pulse on a rejected start.
REQ-012 SHALL have port rd_addr, input, ADDR_W, the index of the schedule word to read.
REQ-013 SHALL have port rd_data, output, 32, the registered value of word w[rd_addr].

Function
REQ-014 SHALL implement states IDLE, EXPAND and DONE; ready=1 in IDLE and DONE only.
REQ-015 SHALL accept start only when ready=1 and key_len is legal.
REQ-016 On accepting start, SHALL in the same edge:
- write w[0..Nk-1] from key_in;
- latch Nk and TOTAL = 44/52/60;
- set i=Nk, phase=0, rcon=8'h01;
- clear valid;
- enter EXPAND.
REQ-017 In EXPAND, SHALL write exactly one word per cycle: w[i] = w[i-Nk] XOR temp.
REQ-018 temp SHALL be selected as follows:
- phase==0: SubWord(RotWord(w[i-1])) XOR {rcon,24'h0};
- Nk==8 and phase==4: SubWord(w[i-1]);
- otherwise: w[i-1].
REQ-019 phase SHALL count i mod Nk by wrapping from Nk-1 to 0; no divider or quotient table is used.
REQ-020 rcon SHALL advance by xtime (shift left, XOR 8'h1B on carry-out) after each phase-0 word, producing 01,02,...,80,1B,36.
REQ-021 After writing w[TOTAL-1], SHALL enter DONE with valid=1 and busy=0.
- Latency from the accepting edge is TOTAL-Nk+1 edges: 41, 47 or 53.
REQ-022 start with key_len=11 while ready=1 SHALL pulse err for one cycle and leave state, memory and valid unchanged.
REQ-023 start while busy=1 SHALL be ignored silently: no err, and the expansion in progress is unaffected.
REQ-024 start accepted in DONE SHALL restart expansion; valid drops on the next edge.
REQ-025 rd_data SHALL have 1-cycle latency and reflect memory contents at any time, including during EXPAND.
REQ-026 rd_addr >= latched TOTAL SHALL return rd_data=0.

Reset
REQ-027 resetn low SHALL immediately force:
- state IDLE;
- ready=1, busy=0, valid=0, err=0, rd_data=0;
- i, phase and rcon to zero;
- all memory words to zero.
REQ-028 Reset asserted mid-EXPAND SHALL abort expansion; no partial schedule is reported valid.

Configuration
REQ-029 Macro KEY_SCHEDULE_AES256_EN SHALL control AES-256 support:
- Defined: 60-word memory and the Nk=8 phase-4 SubWord path are present.
- Undefined: memory depth is 52, the phase-4 path is removed, and key_len=10 is treated as illegal (err pulse per REQ-022).

Structure
REQ-030 A shared package SHALL hold:
- key_len codes;
- Nk and TOTAL constants per mode;
- state encodings;
- initial rcon 8'h01 and the reduction constant 8'h1B.
REQ-031 The S-box SHALL be a combinational sub-module aes_sbox (composite-field GF(2^4) implementation), instantiated four times for SubWord.

Verification
REQ-032 AES-128: key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> w[4]=a0fafe17, w[43]=b6630ca6; valid rises 41 edges after start.
REQ-033 AES-192: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> w[6]=fe0c91f7, w[51]=01002202; latency 47 edges.
REQ-034 AES-256: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> w[8]=9ba35411, w[59]=706c631e; latency 53 edges.
REQ-035 Illegal/busy start: key_len=11 in IDLE -> err=1 for one cycle and ready stays 1; a second start 10 cycles into EXPAND -> ignored, and REQ-032 values still hold.
REQ-036 Reset mid-run: resetn low at EXPAND cycle 20 -> valid=0, ready=1, and rd_data for addr 5 reads 0; a fresh start then completes correctly.
REQ-037 Build without KEY_SCHEDULE_AES256_EN: key_len=10 -> err pulse; rd_addr=55 -> rd_data=0.

Source files
------------

// File: rtl/key_schedule_engine_pkg.sv
// Shared constants, state encoding and helpers for the AES key-schedule engine.
// Nk, TOTAL and rcon constants live here so the datapath and bench agree on them.
package key_schedule_engine_pkg;

    localparam logic [1:0] KLEN_128 = 2'b00;
    localparam logic [1:0] KLEN_192 = 2'b01;
    localparam logic [1:0] KLEN_256 = 2'b10;
    localparam logic [1:0] KLEN_BAD = 2'b11;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;

    localparam logic [5:0] TOTAL_128 = 6'd44;
    localparam logic [5:0] TOTAL_192 = 6'd52;
    localparam logic [5:0] TOTAL_256 = 6'd60;

    localparam int IDX_W = 6;

    localparam logic [7:0] RCON_INIT   = 8'h01;
    localparam logic [7:0] RCON_POLY   = 8'h1B;
    localparam logic [7:0] SBOX_AFFINE = 8'h63;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] r;
        r = {b[6:0], 1'b0};
        if (b[7]) begin
            r = r ^ RCON_POLY;
        end
        return r;
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] klen);
        logic [3:0] r;
        case (klen)
            KLEN_192: r = NK_192;
            KLEN_256: r = NK_256;
            default:  r = NK_128;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] total_of(input logic [1:0] klen);
        logic [5:0] r;
        case (klen)
            KLEN_192: r = TOTAL_192;
            KLEN_256: r = TOTAL_256;
            default:  r = TOTAL_128;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_schedule_engine_sbox.sv
// AES S-box as a composite-field inverter: GF(2^8) -> GF((2^4)^2) -> GF(((2^2)^2)^2)
// in normal bases, with input/output basis changes folded into two 8x8 matrices.
module aes_sbox (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);
    import key_schedule_engine_pkg::*;

    // Rows of the basis-change matrices; X2S also absorbs the affine linear part.
    localparam logic [63:0] A2X = 64'h98F3F2480981A9FF;
    localparam logic [63:0] X2S = 64'h582D9E0BDC040324;

    function automatic logic [7:0] mvm(input logic [7:0] v, input logic [63:0] m);
        logic [7:0] c;
        c = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (v[7-j]) begin
                c = c ^ m[63-8*j -: 8];
            end
        end
        return c;
    endfunction

    function automatic logic [1:0] gf4_mul(input logic [1:0] g, input logic [1:0] d);
        logic a, b, c;
        a = g[1] & d[1];
        b = (g[1] ^ g[0]) & (d[1] ^ d[0]);
        c = g[0] & d[0];
        return {a ^ b, c ^ b};
    endfunction

    function automatic logic [1:0] gf4_scale_w2(input logic [1:0] g);
        return {g[0], g[1] ^ g[0]};
    endfunction

    function automatic logic [1:0] gf4_scale_w(input logic [1:0] g);
        return {g[1] ^ g[0], g[1]};
    endfunction

    function automatic logic [1:0] gf4_sq(input logic [1:0] g);
        return {g[0], g[1]};
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] g, input logic [3:0] d);
        logic [1:0] a, b, c;
        a = gf4_mul(g[3:2], d[3:2]);
        b = gf4_scale_w2(gf4_mul(g[3:2] ^ g[1:0], d[3:2] ^ d[1:0]));
        c = gf4_mul(g[1:0], d[1:0]);
        return {a ^ b, c ^ b};
    endfunction

    function automatic logic [3:0] gf16_sq_scale(input logic [3:0] g);
        logic [1:0] a, b;
        a = g[3:2] ^ g[1:0];
        b = gf4_sq(g[1:0]);
        return {gf4_sq(a), gf4_scale_w(b)};
    endfunction

    function automatic logic [3:0] gf16_inv(input logic [3:0] g);
        logic [1:0] a, b, c, d;
        a = g[3:2] ^ g[1:0];
        b = gf4_mul(g[3:2], g[1:0]);
        c = gf4_scale_w2(gf4_sq(a));
        d = gf4_sq(c ^ b);
        return {gf4_mul(d, g[1:0]), gf4_mul(d, g[3:2])};
    endfunction

    function automatic logic [7:0] gf256_inv(input logic [7:0] g);
        logic [3:0] a, b, c, d;
        a = g[7:4] ^ g[3:0];
        b = gf16_mul(g[7:4], g[3:0]);
        c = gf16_sq_scale(a);
        d = gf16_inv(c ^ b);
        return {gf16_mul(d, g[3:0]), gf16_mul(d, g[7:4])};
    endfunction

    logic [7:0] w_x;
    logic [7:0] w_inv;

    assign w_x    = mvm(i_data, A2X);
    assign w_inv  = gf256_inv(w_x);
    assign o_data = mvm(w_inv, X2S) ^ SBOX_AFFINE;

endmodule

// File: rtl/key_schedule_engine.sv
// AES key expansion engine: one schedule word per cycle into a readable word memory.
// KEY_SCHEDULE_AES256_EN enables the 60-word memory and the Nk=8 SubWord path.
module key_schedule_engine #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [8*WORD_W-1:0]   key_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  valid,
    output logic                  err,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [WORD_W-1:0]     rd_data
);
    import key_schedule_engine_pkg::*;

`ifdef KEY_SCHEDULE_AES256_EN
    localparam int DEPTH = 60;
`else
    localparam int DEPTH = 52;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_mem [DEPTH];
    logic [IDX_W-1:0]    r_i;
    logic [2:0]          r_phase;
    logic [7:0]          r_rcon;
    logic [3:0]          r_nk;
    logic [5:0]          r_total;
    logic                r_err;
    logic [WORD_W-1:0]   r_rd_data;

    logic                w_len_legal;
    logic                w_accept;
    logic                w_reject;
    logic                w_write;
    logic [3:0]          w_nk_sel;
    logic [5:0]          w_total_sel;
    logic [WORD_W-1:0]   w_prev_word;
    logic [WORD_W-1:0]   w_back_word;
    logic [WORD_W-1:0]   w_sub_in;
    logic [WORD_W-1:0]   w_sub_word;
    logic [WORD_W-1:0]   w_temp;
    logic [WORD_W-1:0]   w_new_word;
    logic                w_rd_hit;
    logic [WORD_W-1:0]   w_rd_word;

`ifdef KEY_SCHEDULE_AES256_EN
    assign w_len_legal = (key_len != KLEN_BAD);
`else
    assign w_len_legal = (key_len != KLEN_BAD) && (key_len != KLEN_256);
`endif

    assign w_nk_sel    = nk_of(key_len);
    assign w_total_sel = total_of(key_len);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        ready       = 1'b0;
        busy        = 1'b0;
        valid       = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                ready = 1'b1;
                valid = (r_state == ST_DONE);
                if (start) begin
                    if (w_len_legal) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_EXPAND;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_EXPAND: begin
                busy = 1'b1;
                if (r_i == r_total) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outside EXPAND these indices may wrap; the words read are then unused.
    assign w_prev_word = r_mem[r_i - 6'd1];
    assign w_back_word = r_mem[r_i - {2'b00, r_nk}];
    assign w_sub_in    = (r_phase == 3'd0)
                       ? {w_prev_word[WORD_W-9:0], w_prev_word[WORD_W-1 -: 8]}
                       : w_prev_word;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .i_data (w_sub_in[8*b +: 8]),
            .o_data (w_sub_word[8*b +: 8])
        );
    end

    always_comb begin
        w_temp = w_prev_word;
        if (r_phase == 3'd0) begin
            w_temp = w_sub_word ^ {r_rcon, {(WORD_W-8){1'b0}}};
        end
`ifdef KEY_SCHEDULE_AES256_EN
        else if ((r_nk == NK_256) && (r_phase == 3'd4)) begin
            w_temp = w_sub_word;
        end
`endif
    end

    assign w_new_word = w_back_word ^ w_temp;
    assign w_write    = (r_state == ST_EXPAND) && (r_i != r_total);

    // Only words below the latched TOTAL are readable; anything else reads as zero.
    assign w_rd_hit  = (32'(rd_addr) < 32'(r_total));
    assign w_rd_word = w_rd_hit ? r_mem[IDX_W'(rd_addr)] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_i       <= '0;
            r_phase   <= '0;
            r_rcon    <= '0;
            r_nk      <= '0;
            r_total   <= '0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_err     <= w_reject;
            r_rd_data <= w_rd_word;
            if (w_accept) begin
                for (int k = 0; k < 8; k++) begin
                    if (k < int'(w_nk_sel)) begin
                        r_mem[k] <= key_in[8*WORD_W-1 - WORD_W*k -: WORD_W];
                    end
                end
                r_nk    <= w_nk_sel;
                r_total <= w_total_sel;
                r_i     <= {2'b00, w_nk_sel};
                r_phase <= 3'd0;
                r_rcon  <= RCON_INIT;
            end else if (w_write) begin
                r_mem[r_i] <= w_new_word;
                r_i        <= r_i + 6'd1;
                // phase tracks i mod Nk by wrapping, avoiding any divider
                r_phase    <= ({1'b0, r_phase} == (r_nk - 4'd1)) ? 3'd0 : r_phase + 3'd1;
                if (r_phase == 3'd0) begin
                    r_rcon <= xtime(r_rcon);
                end
            end
        end
    end

    assign err     = r_err;
    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_key_schedule_engine.sv
// Scoreboard bench for key_schedule_engine using FIPS-197 key-expansion vectors.
module tb_key_schedule_engine;

    localparam int K_RD    = 0;
    localparam int K_VALID = 1;
    localparam int K_ERR   = 2;
    localparam int K_READY = 3;
    localparam int K_BUSY  = 4;
    localparam int K_LAT   = 5;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         ready;
    logic         busy;
    logic         valid;
    logic         err;
    logic [5:0]   rd_addr;
    logic [31:0]  rd_data;

    exp_t         sb[$];
    exp_t         item;
    logic [31:0]  act;
    logic         obs = 1'b0;
    int           lat_cnt = 0;
    int           checks = 0;
    int           errors = 0;

    key_schedule_engine #(
        .WORD_W (32),
        .ADDR_W (6)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .key_len (key_len),
        .key_in  (key_in),
        .ready   (ready),
        .busy    (busy),
        .valid   (valid),
        .err     (err),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    // Edges elapsed since the last start seen while ready.
    always @(posedge clk) begin
        if (start === 1'b1 && ready === 1'b1) begin
            lat_cnt <= 0;
        end else begin
            lat_cnt <= lat_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (obs) begin
            while (sb.size() > 0) begin
                item = sb.pop_front();
                case (item.kind)
                    K_RD:    act = rd_data;
                    K_VALID: act = {31'd0, valid};
                    K_ERR:   act = {31'd0, err};
                    K_READY: act = {31'd0, ready};
                    K_BUSY:  act = {31'd0, busy};
                    default: act = 32'(lat_cnt);
                endcase
                checks++;
                if (act !== item.exp) begin
                    errors++;
                    $display("FAIL %s: got %h, expected %h", item.name, act, item.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic observe();
        obs = 1'b1;
        @(negedge clk);
        #1;
        obs = 1'b0;
    endtask

    task automatic check_rd(input logic [5:0] addr, input logic [31:0] exp, input string name);
        rd_addr = addr;
        tick();
        expect_val(K_RD, exp, name);
        observe();
    endtask

    task automatic run_start(input logic [1:0] kl, input logic [255:0] key);
        key_len = kl;
        key_in  = key;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetn  = 1'b0;
        start   = 1'b0;
        key_len = 2'b00;
        key_in  = '0;
        rd_addr = 6'd0;
        tick();
        tick();
        expect_val(K_READY, 32'd1, "reset_ready");
        expect_val(K_BUSY,  32'd0, "reset_busy");
        expect_val(K_VALID, 32'd0, "reset_valid");
        expect_val(K_ERR,   32'd0, "reset_err");
        expect_val(K_RD,    32'd0, "reset_rd_data");
        observe();
        tick();
        resetn = 1'b1;
        tick();

        // Illegal key length from IDLE
        run_start(2'b11, KEY128);
        expect_val(K_ERR,   32'd1, "bad_len_err");
        expect_val(K_READY, 32'd1, "bad_len_ready");
        expect_val(K_BUSY,  32'd0, "bad_len_busy");
        expect_val(K_VALID, 32'd0, "bad_len_valid");
        observe();
        tick();
        expect_val(K_ERR, 32'd0, "bad_len_err_pulse");
        observe();

        // AES-128 with an ignored start ten cycles in
        run_start(2'b00, KEY128);
        expect_val(K_BUSY,  32'd1, "aes128_busy");
        expect_val(K_READY, 32'd0, "aes128_ready");
        observe();
        repeat (9) tick();
        run_start(2'b01, KEY192);
        expect_val(K_ERR,  32'd0, "busy_start_err");
        expect_val(K_BUSY, 32'd1, "busy_start_busy");
        observe();
        wait_valid();
        expect_val(K_LAT, 32'd41, "aes128_latency");
        observe();
        check_rd(6'd0,  32'h2b7e1516, "aes128_w0");
        check_rd(6'd4,  32'ha0fafe17, "aes128_w4");
        check_rd(6'd43, 32'hb6630ca6, "aes128_w43");
        check_rd(6'd44, 32'h00000000, "aes128_w44_oob");

        // AES-192 restarted from DONE
        run_start(2'b01, KEY192);
        expect_val(K_VALID, 32'd0, "aes192_valid_drop");
        expect_val(K_BUSY,  32'd1, "aes192_busy");
        observe();
        wait_valid();
        expect_val(K_LAT, 32'd47, "aes192_latency");
        observe();
        check_rd(6'd0,  32'h8e73b0f7, "aes192_w0");
        check_rd(6'd6,  32'hfe0c91f7, "aes192_w6");
        check_rd(6'd51, 32'h01002202, "aes192_w51");
        check_rd(6'd52, 32'h00000000, "aes192_w52_oob");

        // Illegal start in DONE leaves the schedule intact
        run_start(2'b11, KEY128);
        expect_val(K_ERR,   32'd1, "done_bad_err");
        expect_val(K_VALID, 32'd1, "done_bad_valid");
        expect_val(K_READY, 32'd1, "done_bad_ready");
        observe();
        tick();
        expect_val(K_ERR, 32'd0, "done_bad_err_pulse");
        observe();
        check_rd(6'd51, 32'h01002202, "done_bad_w51");

`ifdef KEY_SCHEDULE_AES256_EN
        run_start(2'b10, KEY256);
        expect_val(K_VALID, 32'd0, "aes256_valid_drop");
        expect_val(K_BUSY,  32'd1, "aes256_busy");
        observe();
        wait_valid();
        expect_val(K_LAT, 32'd53, "aes256_latency");
        observe();
        check_rd(6'd8,  32'h9ba35411, "aes256_w8");
        check_rd(6'd59, 32'h706c631e, "aes256_w59");
        check_rd(6'd60, 32'h00000000, "aes256_w60_oob");
`else
        run_start(2'b10, KEY256);
        expect_val(K_ERR,   32'd1, "no256_err");
        expect_val(K_VALID, 32'd1, "no256_valid");
        expect_val(K_BUSY,  32'd0, "no256_busy");
        observe();
        tick();
        check_rd(6'd55, 32'h00000000, "no256_rd55");
        check_rd(6'd51, 32'h01002202, "no256_w51");
`endif

        // Reset during EXPAND, then a clean run
        run_start(2'b00, KEY128);
        repeat (19) tick();
        rd_addr = 6'd5;
        resetn  = 1'b0;
        expect_val(K_VALID, 32'd0, "midrst_valid");
        expect_val(K_READY, 32'd1, "midrst_ready");
        expect_val(K_BUSY,  32'd0, "midrst_busy");
        expect_val(K_RD,    32'd0, "midrst_rd_data");
        observe();
        tick();
        resetn = 1'b1;
        check_rd(6'd5, 32'h00000000, "midrst_w5");
        run_start(2'b00, KEY128);
        wait_valid();
        expect_val(K_LAT, 32'd41, "rerun_latency");
        observe();
        check_rd(6'd5,  32'h88542cb1, "rerun_w5");
        check_rd(6'd43, 32'hb6630ca6, "rerun_w43");

        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
